// File: rtl/dbuf_pkg.sv
// Shared types and helpers for the ping-pong write-buffer scheduler.
package dbuf_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_FILLING  = 2'd1,
        SLOT_FULL     = 2'd2,
        SLOT_DRAINING = 2'd3
    } slot_state_t;

    localparam int NUM_SLOTS = 2;
    localparam int STAT_W    = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dbuf_slot_ctrl.sv
// One buffer slot: lifecycle state EMPTY -> FILLING -> FULL -> DRAINING and its beat counter.
module dbuf_slot_ctrl
    import dbuf_pkg::*;
#(
    parameter int DEPTH_g = 256,
    parameter int CNT_W_g = $clog2(DEPTH_g + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_fill,
    input  logic               beat,
    input  logic               fill_done,
    input  logic               start_drain,
    input  logic               drain_done,
    output slot_state_t        state,
    output logic [CNT_W_g-1:0] count,
    output logic               overflow
);

    localparam logic [CNT_W_g-1:0] DEPTH_C = CNT_W_g'(DEPTH_g);

    slot_state_t        state_q, state_d;
    logic [CNT_W_g-1:0] count_q, count_d, count_inc;

    // Next-state and counter update; a beat on the done cycle is counted before the empty check.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        count_inc = count_q;
        overflow  = 1'b0;
        case (state_q)
            SLOT_EMPTY: begin
                if (start_fill) begin
                    state_d = SLOT_FILLING;
                    count_d = '0;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FILLING: begin
                if (beat && (count_q == DEPTH_C)) begin
                    overflow = 1'b1;
                end else if (beat) begin
                    count_inc = count_q + {{(CNT_W_g-1){1'b0}}, 1'b1};
                end else begin
                    count_inc = count_q;
                end
                count_d = count_inc;
                if (fill_done) begin
                    state_d = (count_inc == '0) ? SLOT_EMPTY : SLOT_FULL;
                end else begin
                    state_d = SLOT_FILLING;
                end
            end
            SLOT_FULL: begin
                state_d = start_drain ? SLOT_DRAINING : SLOT_FULL;
            end
            SLOT_DRAINING: begin
                if (drain_done) begin
                    state_d = SLOT_EMPTY;
                    count_d = '0;
                end else begin
                    state_d = SLOT_DRAINING;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
                count_d = '0;
            end
        endcase
    end

    // Slot state and beat-count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SLOT_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state = state_q;
    assign count = count_q;

endmodule

// File: rtl/dbuf_pingpong_sched.sv
// Two-slot ping-pong write-buffer scheduler: grant, fill-order offer, recycle, sticky error.
// Optional statistics counters are built when DBUF_SCHED_STATS_EN is defined.
module dbuf_pingpong_sched
    import dbuf_pkg::*;
#(
    parameter int DEPTH_g = 256,
    parameter int CNT_W_g = $clog2(DEPTH_g + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_req_i,
    output logic               wr_gnt_o,
    output logic               wr_sel_o,
    input  logic               wr_beat_i,
    input  logic               wr_done_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic               rd_sel_o,
    output logic [CNT_W_g-1:0] rd_len_o,
    input  logic               rd_done_i,
    output logic               err_o
`ifdef DBUF_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_fills_o,
    output logic [STAT_W-1:0]  stat_drains_o,
    output logic [STAT_W-1:0]  stat_stall_o
`endif
);

    slot_state_t          st_s  [NUM_SLOTS];
    logic [CNT_W_g-1:0]   cnt_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] ovf_s, start_fill_s, beat_s, fill_done_s, start_drain_s, drain_done_s;
    logic any_empty_s, any_filling_s, any_draining_s;
    logic empty_idx_s, fill_idx_s, drain_idx_s, other_fill_s, other_order_s, rd_sel_s;
    logic gnt_s, offer_s, accept_s, fill_ok_s, fill_nonempty_s, drain_ok_s;
    logic wr_sel_q, wr_sel_d, order_q, order_d, err_q, err_d;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        dbuf_slot_ctrl #(
            .DEPTH_g (DEPTH_g),
            .CNT_W_g (CNT_W_g)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .start_fill  (start_fill_s[g]),
            .beat        (beat_s[g]),
            .fill_done   (fill_done_s[g]),
            .start_drain (start_drain_s[g]),
            .drain_done  (drain_done_s[g]),
            .state       (st_s[g]),
            .count       (cnt_s[g]),
            .overflow    (ovf_s[g])
        );
    end

    // Slot-state summary; scanning downwards leaves the lowest EMPTY index selected.
    always_comb begin
        any_empty_s    = 1'b0;
        any_filling_s  = 1'b0;
        any_draining_s = 1'b0;
        empty_idx_s    = 1'b0;
        fill_idx_s     = 1'b0;
        drain_idx_s    = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            case (st_s[i])
                SLOT_EMPTY:    begin any_empty_s    = 1'b1; empty_idx_s = 1'(i); end
                SLOT_FILLING:  begin any_filling_s  = 1'b1; fill_idx_s  = 1'(i); end
                SLOT_DRAINING: begin any_draining_s = 1'b1; drain_idx_s = 1'(i); end
                default:       begin any_empty_s    = any_empty_s; end
            endcase
        end
    end

    // Grant/offer arbitration, slot strobes, fill-order pointer and error accumulation.
    always_comb begin
        gnt_s           = wr_req_i & any_empty_s & ~any_filling_s;
        offer_s         = (st_s[order_q] == SLOT_FULL) & ~any_draining_s;
        accept_s        = offer_s & rd_ready_i;
        fill_ok_s       = wr_done_i & any_filling_s;
        fill_nonempty_s = fill_ok_s & ((cnt_s[fill_idx_s] != '0) | wr_beat_i);
        drain_ok_s      = rd_done_i & any_draining_s;
        other_fill_s    = ~fill_idx_s;
        other_order_s   = ~order_q;
        rd_sel_s        = any_draining_s ? drain_idx_s : order_q;

        start_fill_s  = '0;
        beat_s        = '0;
        fill_done_s   = '0;
        start_drain_s = '0;
        drain_done_s  = '0;
        start_fill_s[empty_idx_s]  = gnt_s;
        beat_s[fill_idx_s]         = wr_beat_i & any_filling_s;
        fill_done_s[fill_idx_s]    = fill_ok_s;
        start_drain_s[order_q]     = accept_s;
        drain_done_s[drain_idx_s]  = drain_ok_s;

        // A completed fill is the oldest only if no other slot stays FULL past this cycle.
        if (fill_nonempty_s && !((st_s[other_fill_s] == SLOT_FULL) && !accept_s)) begin
            order_d = fill_idx_s;
        end else if (!fill_nonempty_s && accept_s && (st_s[other_order_s] == SLOT_FULL)) begin
            order_d = other_order_s;
        end else begin
            order_d = order_q;
        end

        wr_sel_d = gnt_s ? empty_idx_s : wr_sel_q;
        err_d    = err_q | (|ovf_s)
                 | ((wr_beat_i | wr_done_i) & ~any_filling_s)
                 | (rd_done_i & ~any_draining_s);
    end

    // Scheduler registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sel_q <= 1'b0;
            order_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            order_q  <= order_d;
            err_q    <= err_d;
        end
    end

    assign wr_gnt_o   = gnt_s;
    assign wr_sel_o   = wr_sel_q;
    assign rd_valid_o = offer_s;
    assign rd_sel_o   = rd_sel_s;
    assign rd_len_o   = cnt_s[rd_sel_s];
    assign err_o      = err_q;

`ifdef DBUF_SCHED_STATS_EN
    logic [STAT_W-1:0] fills_q, fills_d, drains_q, drains_d, stall_q, stall_d;

    // Saturating statistics next values.
    always_comb begin
        fills_d  = fill_nonempty_s         ? sat_inc(fills_q)  : fills_q;
        drains_d = drain_ok_s              ? sat_inc(drains_q) : drains_q;
        stall_d  = (wr_req_i & ~gnt_s)     ? sat_inc(stall_q)  : stall_q;
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fills_q  <= '0;
            drains_q <= '0;
            stall_q  <= '0;
        end else begin
            fills_q  <= fills_d;
            drains_q <= drains_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_fills_o  = fills_q;
    assign stat_drains_o = drains_q;
    assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_dbuf_pingpong_sched.sv
// Directed self-checking bench for dbuf_pingpong_sched (DEPTH_g = 8, so rd_len_o is 4 bits).
module tb_dbuf_pingpong_sched;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_req_i = 1'b0, wr_beat_i = 1'b0, wr_done_i = 1'b0;
    logic       rd_ready_i = 1'b0, rd_done_i = 1'b0;
    logic       wr_gnt_o, wr_sel_o, rd_valid_o, rd_sel_o, err_o;
    logic [3:0] rd_len_o;
`ifdef DBUF_SCHED_STATS_EN
    logic [31:0] stat_fills_o, stat_drains_o, stat_stall_o;
`endif

    int nvec = 0;
    int nerr = 0;

    dbuf_pingpong_sched #(.DEPTH_g(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_req_i   (wr_req_i),
        .wr_gnt_o   (wr_gnt_o),
        .wr_sel_o   (wr_sel_o),
        .wr_beat_i  (wr_beat_i),
        .wr_done_i  (wr_done_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_sel_o   (rd_sel_o),
        .rd_len_o   (rd_len_o),
        .rd_done_i  (rd_done_i),
        .err_o      (err_o)
`ifdef DBUF_SCHED_STATS_EN
        ,
        .stat_fills_o  (stat_fills_o),
        .stat_drains_o (stat_drains_o),
        .stat_stall_o  (stat_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1; wr_req_i = 1'b0; wr_beat_i = 1'b0; wr_done_i = 1'b0;
        rd_ready_i = 1'b0; rd_done_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic do_fill(input int n);
        wr_req_i = 1'b1; tick(); wr_req_i = 1'b0;
        wr_beat_i = 1'b1;
        repeat (n) tick();
        wr_beat_i = 1'b0; wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
    endtask

    task automatic do_drain();
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        rd_done_i = 1'b1; tick(); rd_done_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        nvec++; if (wr_gnt_o !== 1'b0)   begin nerr++; $display("FAIL rst_gnt: got %0b want 0", wr_gnt_o); end
        nvec++; if (wr_sel_o !== 1'b0)   begin nerr++; $display("FAIL rst_wr_sel: got %0b want 0", wr_sel_o); end
        nvec++; if (rd_sel_o !== 1'b0)   begin nerr++; $display("FAIL rst_rd_sel: got %0b want 0", rd_sel_o); end
        nvec++; if (rd_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %0b want 0", rd_valid_o); end
        nvec++; if (rd_len_o !== 4'd0)   begin nerr++; $display("FAIL rst_len: got %0d want 0", rd_len_o); end
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL rst_err: got %0b want 0", err_o); end
`ifdef DBUF_SCHED_STATS_EN
        nvec++; if ({stat_fills_o, stat_drains_o, stat_stall_o} !== 96'd0) begin
            nerr++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", stat_fills_o, stat_drains_o, stat_stall_o);
        end
`endif
    endtask

    task automatic test_single_pass();
        apply_reset();
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b1) begin nerr++; $display("FAIL sp_gnt: got %0b want 1", wr_gnt_o); end
        tick(); wr_req_i = 1'b0;
        nvec++; if (wr_sel_o !== 1'b0) begin nerr++; $display("FAIL sp_wr_sel: got %0b want 0", wr_sel_o); end
        wr_beat_i = 1'b1; repeat (4) tick(); wr_beat_i = 1'b0;
        wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL sp_valid: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_sel_o !== 1'b0)   begin nerr++; $display("FAIL sp_rd_sel: got %0b want 0", rd_sel_o); end
        nvec++; if (rd_len_o !== 4'd4)   begin nerr++; $display("FAIL sp_len: got %0d want 4", rd_len_o); end
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b0) begin nerr++; $display("FAIL sp_valid_drop: got %0b want 0", rd_valid_o); end
        rd_done_i = 1'b1; tick(); rd_done_i = 1'b0;
        nvec++; if (rd_len_o !== 4'd0)   begin nerr++; $display("FAIL sp_len_clr: got %0d want 0", rd_len_o); end
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL sp_err: got %0b want 0", err_o); end
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b1)   begin nerr++; $display("FAIL sp_regrant: got %0b want 1", wr_gnt_o); end
        wr_req_i = 1'b0;
    endtask

    task automatic test_ping_pong();
        apply_reset();
        do_fill(3);
        do_fill(5);
        nvec++; if (wr_sel_o !== 1'b1)   begin nerr++; $display("FAIL pp_wr_sel: got %0b want 1", wr_sel_o); end
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL pp_valid0: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_sel_o !== 1'b0)   begin nerr++; $display("FAIL pp_sel0: got %0b want 0", rd_sel_o); end
        nvec++; if (rd_len_o !== 4'd3)   begin nerr++; $display("FAIL pp_len0: got %0d want 3", rd_len_o); end
        wr_req_i = 1'b1; tick();
        nvec++; if (wr_gnt_o !== 1'b0)   begin nerr++; $display("FAIL pp_third_gnt: got %0b want 0", wr_gnt_o); end
        nvec++; if ({rd_sel_o, rd_len_o} !== {1'b0, 4'd3}) begin nerr++; $display("FAIL pp_hold: got sel %0b len %0d want sel 0 len 3", rd_sel_o, rd_len_o); end
        wr_req_i = 1'b0;
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b0)   begin nerr++; $display("FAIL pp_gnt_draining: got %0b want 0", wr_gnt_o); end
        wr_req_i = 1'b0;
        rd_done_i = 1'b1; tick(); rd_done_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL pp_valid1: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_sel_o !== 1'b1)   begin nerr++; $display("FAIL pp_sel1: got %0b want 1", rd_sel_o); end
        nvec++; if (rd_len_o !== 4'd5)   begin nerr++; $display("FAIL pp_len1: got %0d want 5", rd_len_o); end
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b1)   begin nerr++; $display("FAIL pp_gnt_after_drain: got %0b want 1", wr_gnt_o); end
        wr_req_i = 1'b0;
        do_drain();
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL pp_err: got %0b want 0", err_o); end
    endtask

    task automatic test_overflow();
        apply_reset();
        wr_req_i = 1'b1; tick(); wr_req_i = 1'b0;
        wr_beat_i = 1'b1; repeat (8) tick();
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL ov_err_at_cap: got %0b want 0", err_o); end
        repeat (2) tick(); wr_beat_i = 1'b0;
        nvec++; if (err_o !== 1'b1)      begin nerr++; $display("FAIL ov_err_set: got %0b want 1", err_o); end
        wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL ov_valid: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_len_o !== 4'd8)   begin nerr++; $display("FAIL ov_len: got %0d want 8", rd_len_o); end
        do_drain();
        nvec++; if (err_o !== 1'b1)      begin nerr++; $display("FAIL ov_err_sticky: got %0b want 1", err_o); end
    endtask

    task automatic test_zero_and_stray();
        apply_reset();
        wr_req_i = 1'b1; tick(); wr_req_i = 1'b0;
        wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b0) begin nerr++; $display("FAIL zl_valid: got %0b want 0", rd_valid_o); end
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL zl_err: got %0b want 0", err_o); end
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b1)   begin nerr++; $display("FAIL zl_empty_gnt: got %0b want 1", wr_gnt_o); end
        wr_req_i = 1'b0;
        do_fill(2);
        rd_done_i = 1'b1; tick(); rd_done_i = 1'b0;
        nvec++; if (err_o !== 1'b1)      begin nerr++; $display("FAIL st_err: got %0b want 1", err_o); end
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL st_valid_kept: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_len_o !== 4'd2)   begin nerr++; $display("FAIL st_len_kept: got %0d want 2", rd_len_o); end
    endtask

    task automatic test_concurrency();
        apply_reset();
        do_fill(2);
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        wr_req_i = 1'b1; tick(); wr_req_i = 1'b0;
        nvec++; if (wr_sel_o !== 1'b1)   begin nerr++; $display("FAIL cc_wr_sel: got %0b want 1", wr_sel_o); end
        wr_beat_i = 1'b1; repeat (3) tick(); wr_beat_i = 1'b0;
        wr_done_i = 1'b1; rd_done_i = 1'b1; wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b0)   begin nerr++; $display("FAIL cc_gnt_on_done: got %0b want 0", wr_gnt_o); end
        tick(); wr_done_i = 1'b0; rd_done_i = 1'b0;
        nvec++; if (wr_gnt_o !== 1'b1)   begin nerr++; $display("FAIL cc_gnt_next: got %0b want 1", wr_gnt_o); end
        wr_req_i = 1'b0;
        nvec++; if (rd_valid_o !== 1'b1) begin nerr++; $display("FAIL cc_valid: got %0b want 1", rd_valid_o); end
        nvec++; if (rd_sel_o !== 1'b1)   begin nerr++; $display("FAIL cc_sel: got %0b want 1", rd_sel_o); end
        nvec++; if (rd_len_o !== 4'd3)   begin nerr++; $display("FAIL cc_len: got %0d want 3", rd_len_o); end
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL cc_err: got %0b want 0", err_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_fill(2);
        wr_req_i = 1'b1; tick(); wr_req_i = 1'b0;
        wr_beat_i = 1'b1; tick(); wr_beat_i = 1'b0;
        rd_done_i = 1'b1; tick(); rd_done_i = 1'b0;
        nvec++; if ({wr_sel_o, err_o, rd_valid_o} !== 3'b111) begin nerr++; $display("FAIL rm_pre: got sel/err/valid %b%b%b want 111", wr_sel_o, err_o, rd_valid_o); end
        rst_i = 1'b1; wr_beat_i = 1'b1; tick(); rst_i = 1'b0; wr_beat_i = 1'b0;
        nvec++; if (wr_sel_o !== 1'b0)   begin nerr++; $display("FAIL rm_wr_sel: got %0b want 0", wr_sel_o); end
        nvec++; if (rd_valid_o !== 1'b0) begin nerr++; $display("FAIL rm_valid: got %0b want 0", rd_valid_o); end
        nvec++; if (rd_len_o !== 4'd0)   begin nerr++; $display("FAIL rm_len: got %0d want 0", rd_len_o); end
        nvec++; if (err_o !== 1'b0)      begin nerr++; $display("FAIL rm_err: got %0b want 0", err_o); end
        wr_req_i = 1'b1; #1;
        nvec++; if (wr_gnt_o !== 1'b1)   begin nerr++; $display("FAIL rm_gnt: got %0b want 1", wr_gnt_o); end
        wr_req_i = 1'b0;
    endtask

`ifdef DBUF_SCHED_STATS_EN
    task automatic test_stats();
        apply_reset();
        do_fill(1);
        do_fill(1);
        wr_req_i = 1'b1; repeat (7) tick(); wr_req_i = 1'b0;
        do_drain();
        do_fill(1);
        do_drain();
        nvec++; if (stat_fills_o !== 32'd3)  begin nerr++; $display("FAIL stat_fills: got %0d want 3", stat_fills_o); end
        nvec++; if (stat_drains_o !== 32'd2) begin nerr++; $display("FAIL stat_drains: got %0d want 2", stat_drains_o); end
        nvec++; if (stat_stall_o !== 32'd7)  begin nerr++; $display("FAIL stat_stall: got %0d want 7", stat_stall_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_ping_pong();
        test_overflow();
        test_zero_and_stray();
        test_concurrency();
        test_reset_mid();
`ifdef DBUF_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
